// File: rtl/cpu7_ifu_pkg.sv
// rtl/cpu7_ifu_pkg.sv - shared types and constants for the IFU instruction-bus bridge
package cpu7_ifu_pkg;

  localparam logic [5:0] EXC_ADEF = 6'h08;

  typedef struct packed {
    logic drop;
    logic is_local;
    logic unc;
  } tag_t;

endpackage

// File: rtl/cpu7_ifu_tagq.sv
// rtl/cpu7_ifu_tagq.sv - in-order tag FIFO for outstanding fetches with drop-all marking
module cpu7_ifu_tagq
  import cpu7_ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  input  logic drop_all,
  output tag_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  tag_t          entries_q [DEPTH];
  tag_t          entries_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = entries_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    // Marking stale slots is harmless: a push always writes a fresh tag.
    if (drop_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].drop = 1'b1;
      end
    end
    if (do_push) begin
      entries_d[wr_ptr_q] = push_tag;
      wr_ptr_d            = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/cpu7_ifu_ibus_bridge.sv
// rtl/cpu7_ifu_ibus_bridge.sv - IFU fetch request to SRAM-like instruction bus bridge
module cpu7_ifu_ibus_bridge
  import cpu7_ifu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          GRLEN    = 64,
  parameter logic [31:0] UNC_BASE = 32'h1c00_0000,
  parameter logic [31:0] UNC_MASK = 32'hff00_0000
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             inst_req,
  input  logic [31:0]      inst_addr,
  output logic             inst_addr_ok,
  input  logic             inst_cancel,
  output logic             inst_valid_f,
  output logic [GRLEN-1:0] inst_rdata_f,
  output logic [1:0]       inst_count,
  output logic             inst_uncache,
  output logic             inst_ex,
  output logic [5:0]       inst_exccode,
  output logic             ibus_req,
  output logic [31:0]      ibus_addr,
  input  logic             ibus_gnt,
  input  logic             ibus_rvalid,
  input  logic [31:0]      ibus_rdata,
  input  logic             ibus_err
);

  tag_t head, push_tag;
  logic full, empty;
  logic misaligned, can, pop;

  logic             valid_q, valid_d;
  logic [1:0]       count_q, count_d;
  logic [GRLEN-1:0] rdata_q, rdata_d;
  logic             unc_q, unc_d;
  logic             ex_q, ex_d;
  logic [5:0]       code_q, code_d;

  assign misaligned   = |inst_addr[1:0];
  assign can          = inst_req & ~full & ~inst_cancel;
  assign ibus_req     = can & ~misaligned;
  assign ibus_addr    = inst_addr;
  assign inst_addr_ok = misaligned ? can : (can & ibus_gnt);

  assign push_tag.drop     = 1'b0;
  assign push_tag.is_local = misaligned;
  assign push_tag.unc      = ((inst_addr & UNC_MASK) == UNC_BASE);

  // A local head always retires on its first head cycle; bus beats only ever
  // belong to a bus head, so an rvalid seen under a local head is not consumed.
  assign pop = ~empty & (head.is_local | ibus_rvalid);

  cpu7_ifu_tagq #(
    .DEPTH (DEPTH)
  ) u_tagq (
    .clock    (clock),
    .resetn   (resetn),
    .push     (inst_addr_ok),
    .push_tag (push_tag),
    .pop      (pop),
    .drop_all (inst_cancel),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    valid_d = 1'b0;
    count_d = 2'd0;
    rdata_d = '0;
    unc_d   = 1'b0;
    ex_d    = 1'b0;
    code_d  = 6'd0;
    // A cancel in the pop cycle kills the popping head as well.
    if (pop && !head.drop && !inst_cancel) begin
      valid_d = 1'b1;
      count_d = 2'd1;
      unc_d   = head.unc;
      if (head.is_local || ibus_err) begin
        ex_d   = 1'b1;
        code_d = EXC_ADEF;
      end else begin
        rdata_d = GRLEN'(ibus_rdata);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      count_q <= 2'd0;
      rdata_q <= '0;
      unc_q   <= 1'b0;
      ex_q    <= 1'b0;
      code_q  <= 6'd0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      unc_q   <= unc_d;
      ex_q    <= ex_d;
      code_q  <= code_d;
    end
  end

  assign inst_valid_f = valid_q;
  assign inst_count   = count_q;
  assign inst_rdata_f = rdata_q;
  assign inst_uncache = unc_q;
  assign inst_ex      = ex_q;
  assign inst_exccode = code_q;

endmodule

// File: tb/tb_cpu7_ifu_ibus_bridge.sv
// tb/tb_cpu7_ifu_ibus_bridge.sv - randomized self-checking bench with a queue-level reference model
module tb_cpu7_ifu_ibus_bridge;

  localparam int          DEPTH    = 4;
  localparam int          GRLEN    = 64;
  localparam logic [31:0] UNC_BASE = 32'h1c00_0000;
  localparam logic [31:0] UNC_MASK = 32'hff00_0000;

  logic             clock = 1'b0;
  logic             resetn;
  logic             inst_req;
  logic [31:0]      inst_addr;
  logic             inst_addr_ok;
  logic             inst_cancel;
  logic             inst_valid_f;
  logic [GRLEN-1:0] inst_rdata_f;
  logic [1:0]       inst_count;
  logic             inst_uncache;
  logic             inst_ex;
  logic [5:0]       inst_exccode;
  logic             ibus_req;
  logic [31:0]      ibus_addr;
  logic             ibus_gnt;
  logic             ibus_rvalid;
  logic [31:0]      ibus_rdata;
  logic             ibus_err;

  always #5 clock = ~clock;

  cpu7_ifu_ibus_bridge #(
    .DEPTH    (DEPTH),
    .GRLEN    (GRLEN),
    .UNC_BASE (UNC_BASE),
    .UNC_MASK (UNC_MASK)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_cancel  (inst_cancel),
    .inst_valid_f (inst_valid_f),
    .inst_rdata_f (inst_rdata_f),
    .inst_count   (inst_count),
    .inst_uncache (inst_uncache),
    .inst_ex      (inst_ex),
    .inst_exccode (inst_exccode),
    .ibus_req     (ibus_req),
    .ibus_addr    (ibus_addr),
    .ibus_gnt     (ibus_gnt),
    .ibus_rvalid  (ibus_rvalid),
    .ibus_rdata   (ibus_rdata),
    .ibus_err     (ibus_err)
  );

  typedef struct {
    bit drop;
    bit lcl;
    bit unc;
  } ent_t;

  ent_t q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  logic             exp_valid, exp_unc, exp_ex;
  logic [1:0]       exp_cnt;
  logic [GRLEN-1:0] exp_rdata;
  logic [5:0]       exp_code;
  logic             obs_ok, obs_req;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("valid", 64'(inst_valid_f), 64'(exp_valid));
    check("count", 64'(inst_count), 64'(exp_cnt));
    check("rdata", 64'(inst_rdata_f), 64'(exp_rdata));
    check("uncache", 64'(inst_uncache), 64'(exp_unc));
    check("ex", 64'(inst_ex), 64'(exp_ex));
    check("exccode", 64'(inst_exccode), 64'(exp_code));
  endtask

  task automatic clear_exp();
    exp_valid = 1'b0;
    exp_cnt   = 2'd0;
    exp_rdata = '0;
    exp_unc   = 1'b0;
    exp_ex    = 1'b0;
    exp_code  = 6'd0;
  endtask

  task automatic drive_idle();
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    inst_cancel = 1'b0;
    ibus_gnt    = 1'b0;
    ibus_rvalid = 1'b0;
    ibus_rdata  = 32'h0;
    ibus_err    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    drive_idle();
    q.delete();
    clear_exp();
    #1;
    check_outputs();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  // One clock of stimulus; the model is advanced at the level of whole fetches.
  task automatic step(input logic req, input logic [31:0] addr, input logic gnt,
                      input logic rv, input logic [31:0] rd, input logic err,
                      input logic cancel);
    bit   mis, can, acc;
    ent_t e;
    @(negedge clock);
    inst_req    = req;
    inst_addr   = addr;
    ibus_gnt    = gnt;
    ibus_rvalid = rv;
    ibus_rdata  = rd;
    ibus_err    = err;
    inst_cancel = cancel;
    #1;
    mis = (addr[1:0] != 2'b00);
    can = req && (q.size() < DEPTH) && !cancel;
    acc = can && (mis || gnt);
    obs_ok  = inst_addr_ok;
    obs_req = ibus_req;
    check("addr_ok", 64'(inst_addr_ok), 64'(acc));
    check("ibus_req", 64'(ibus_req), 64'(can && !mis));
    check("ibus_addr", 64'(ibus_addr), 64'(addr));
    clear_exp();
    if (q.size() > 0 && (q[0].lcl || rv)) begin
      e = q.pop_front();
      if (!e.drop && !cancel) begin
        exp_valid = 1'b1;
        exp_cnt   = 2'd1;
        exp_unc   = e.unc;
        if (e.lcl || err) begin
          exp_ex   = 1'b1;
          exp_code = 6'h08;
        end else begin
          exp_rdata = GRLEN'(rd);
        end
      end
    end
    if (cancel) begin
      foreach (q[i]) q[i].drop = 1'b1;
    end
    if (acc) begin
      e.drop = 1'b0;
      e.lcl  = mis;
      e.unc  = ((addr & UNC_MASK) == UNC_BASE);
      q.push_back(e);
    end
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic rv, input logic [31:0] rd, input logic err);
    step(1'b0, 32'h0, 1'b0, rv, rd, err, 1'b0);
  endtask

  initial begin
    bit          has_bus, rv_ok;
    logic [31:0] a;
    resetn = 1'b0;
    drive_idle();
    clear_exp();
    #12;
    check_outputs();
    check("rst_addr_ok", 64'(inst_addr_ok), 64'd0);
    check("rst_ibus_req", 64'(ibus_req), 64'd0);
    resetn = 1'b1;

    // back-to-back uncached fetches
    step(1'b1, 32'h1c00_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h1c00_0004, 1'b1, 1'b1, 32'h02c0_0000, 1'b0, 1'b0);
    check("b2b_beat0", 64'(inst_rdata_f), 64'h02c0_0000);
    check("b2b_unc0", 64'(inst_uncache), 64'd1);
    idle(1'b1, 32'h002a_0000, 1'b0);
    check("b2b_beat1", 64'(inst_rdata_f), 64'h002a_0000);
    check("b2b_cnt1", 64'(inst_count), 64'd1);

    // fill to DEPTH, full blocks even with a same-cycle pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h0000_1000 + 32'(i * 4), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("full_addr_ok", 64'(obs_ok), 64'd0);
    check("full_ibus_req", 64'(obs_req), 64'd0);
    step(1'b1, 32'h0000_2000, 1'b1, 1'b1, 32'h1111_0000, 1'b0, 1'b0);
    check("full_pop_blocked", 64'(obs_ok), 64'd0);
    step(1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("refill_ok", 64'(obs_ok), 64'd1);
    for (int i = 0; i < DEPTH; i++) idle(1'b1, 32'h2222_0000 + 32'(i), 1'b0);

    // misaligned fetch
    step(1'b1, 32'h8000_0002, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("mis_no_req", 64'(obs_req), 64'd0);
    check("mis_ok", 64'(obs_ok), 64'd1);
    idle(1'b0, 32'h0, 1'b0);
    check("mis_ex", 64'(inst_ex), 64'd1);
    check("mis_code", 64'(inst_exccode), 64'h08);
    check("mis_rdata", 64'(inst_rdata_f), 64'd0);

    // cancel with three outstanding
    for (int i = 0; i < 3; i++) step(1'b1, 32'h1c00_0100 + 32'(i * 4), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h1c00_0200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check("cancel_refuse", 64'(obs_ok), 64'd0);
    step(1'b1, 32'h8000_0100, 1'b1, 1'b1, 32'hdead_0001, 1'b0, 1'b0);
    idle(1'b1, 32'hdead_0002, 1'b0);
    idle(1'b1, 32'hdead_0003, 1'b0);
    check("cancel_drop", 64'(inst_valid_f), 64'd0);
    idle(1'b1, 32'h1234_5678, 1'b0);
    check("post_cancel_data", 64'(inst_rdata_f), 64'h1234_5678);
    check("post_cancel_unc", 64'(inst_uncache), 64'd0);

    // bus error
    step(1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1'b1, 32'hffff_ffff, 1'b1);
    check("err_ex", 64'(inst_ex), 64'd1);
    check("err_code", 64'(inst_exccode), 64'h08);

    // reset with two outstanding, then a stray response
    step(1'b1, 32'h0000_4000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_4004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    do_reset();
    idle(1'b1, 32'habcd_ef01, 1'b0);
    check("stray_valid", 64'(inst_valid_f), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      has_bus = 1'b0;
      foreach (q[i]) if (!q[i].lcl) has_bus = 1'b1;
      rv_ok = (q.size() > 0 && !q[0].lcl) || !has_bus;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[31:24] = 8'h1c;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0,
           rv_ok && ($urandom_range(0, 1) == 1), $urandom,
           $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
      if (n % 1000 == 999) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
